// File: rtl/npu_dsp_pkg.sv
// Shared definitions for the DSP multiplier/accumulator bank and the engines that drive it.
package npu_dsp_pkg;

    typedef enum logic [1:0] {
        DSP_MUL = 2'd0,
        DSP_MAC = 2'd1,
        DSP_LDA = 2'd2,
        DSP_CLR = 2'd3
    } dsp_op_e;

    localparam int DSP_A_W   = 18;
    localparam int DSP_P_W   = 36;
    localparam int DSP_OUT_W = 37;
    localparam int DSP_LANES = 5;

    // 18x18 product, zero- or sign-extended to the 37-bit result width.
    function automatic logic [DSP_OUT_W-1:0] dsp_mul_ext(
        input logic [DSP_A_W-1:0] a,
        input logic [DSP_A_W-1:0] b,
        input logic               sgn
    );
        logic        [DSP_P_W-1:0] pu;
        logic signed [DSP_P_W-1:0] ps;
        pu = {{(DSP_P_W-DSP_A_W){1'b0}}, a} * {{(DSP_P_W-DSP_A_W){1'b0}}, b};
        ps = $signed({{(DSP_P_W-DSP_A_W){a[DSP_A_W-1]}}, a}) *
             $signed({{(DSP_P_W-DSP_A_W){b[DSP_A_W-1]}}, b});
        return sgn ? {ps[DSP_P_W-1], ps} : {1'b0, pu};
    endfunction

endpackage

// File: rtl/dsp_mac_lane.sv
// One multiplier lane: operand capture, product pipeline, result stage with
// accumulator and sticky overflow. Op/valid tags arrive already aligned to the result stage.
module dsp_mac_lane
    import npu_dsp_pkg::*;
#(
    parameter int PIPE_STAGES = 2,
    parameter int SIGNED_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 vld,
    input  logic [1:0]           op,
    input  logic [DSP_A_W-1:0]   a,
    input  logic [DSP_A_W-1:0]   b,
    output logic [DSP_OUT_W-1:0] out,
    output logic                 ovf
);

    function automatic logic mac_overflow(
        input logic [DSP_OUT_W-1:0] acc_v,
        input logic [DSP_OUT_W-1:0] p_v,
        input logic [DSP_OUT_W:0]   sum_v
    );
        if (SIGNED_MODE != 0)
            return (acc_v[DSP_OUT_W-1] == p_v[DSP_OUT_W-1]) &&
                   (sum_v[DSP_OUT_W-1] != acc_v[DSP_OUT_W-1]);
        return sum_v[DSP_OUT_W];
    endfunction

    logic [DSP_A_W-1:0]   a_p0, b_p0;
    logic [DSP_OUT_W-1:0] prod_p0, prod_res;
    logic [DSP_OUT_W-1:0] acc;
    logic [DSP_OUT_W:0]   sum;

    // Stage 0: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p0 <= '0;
            b_p0 <= '0;
        end else if (ce) begin
            a_p0 <= a;
            b_p0 <= b;
        end
    end

    assign prod_p0 = dsp_mul_ext(a_p0, b_p0, SIGNED_MODE != 0);

    // Stages 1..PIPE_STAGES-1: product registers
    if (PIPE_STAGES == 1) begin : g_nopipe
        assign prod_res = prod_p0;
    end else begin : g_pipe
        logic [DSP_OUT_W-1:0] prod_pn [PIPE_STAGES-1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < PIPE_STAGES-1; i++) prod_pn[i] <= '0;
            end else if (ce) begin
                prod_pn[0] <= prod_p0;
                for (int i = 1; i < PIPE_STAGES-1; i++) prod_pn[i] <= prod_pn[i-1];
            end
        end
        assign prod_res = prod_pn[PIPE_STAGES-2];
    end

    assign sum = {1'b0, acc} + {1'b0, prod_res};

    // Result stage: accumulator feeds back here so consecutive MACs chain without a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            out <= '0;
            ovf <= 1'b0;
        end else if (ce && vld) begin
            case (dsp_op_e'(op))
                DSP_MUL: out <= prod_res;
                DSP_MAC: begin
                    acc <= sum[DSP_OUT_W-1:0];
                    out <= sum[DSP_OUT_W-1:0];
                    if (mac_overflow(acc, prod_res, sum)) ovf <= 1'b1;
                end
                DSP_LDA: begin
                    acc <= prod_res;
                    out <= prod_res;
                end
                DSP_CLR: begin
                    acc <= '0;
                    out <= '0;
                    ovf <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dsp_mac_bank.sv
// Bank of LANES multiply/accumulate lanes sharing one op/valid tag pipeline.
// PIPE_STAGES is meaningful for 1..4.
module dsp_mac_bank
    import npu_dsp_pkg::*;
#(
    parameter int LANES       = DSP_LANES,
    parameter int PIPE_STAGES = 2,
    parameter int SIGNED_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         dsp_ce,
    input  logic                         dsp_vld,
    input  logic [1:0]                   dsp_op,
    input  logic [LANES*DSP_A_W-1:0]     dsp_a0,
    input  logic [LANES*DSP_A_W-1:0]     dsp_b0,
    output logic [LANES*DSP_OUT_W-1:0]   dsp_out,
    output logic                         dsp_out_vld,
    output logic [LANES-1:0]             dsp_ovf
);

    logic       vld_p0, vld_res;
    logic [1:0] op_p0, op_res;

    // Stage 0: tag capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            op_p0  <= '0;
        end else if (dsp_ce) begin
            vld_p0 <= dsp_vld;
            op_p0  <= dsp_op;
        end
    end

    // Stages 1..PIPE_STAGES-1: tags travel alongside the products
    if (PIPE_STAGES == 1) begin : g_notag
        assign vld_res = vld_p0;
        assign op_res  = op_p0;
    end else begin : g_tag
        logic       vld_pn [PIPE_STAGES-1];
        logic [1:0] op_pn  [PIPE_STAGES-1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < PIPE_STAGES-1; i++) begin
                    vld_pn[i] <= 1'b0;
                    op_pn[i]  <= '0;
                end
            end else if (dsp_ce) begin
                vld_pn[0] <= vld_p0;
                op_pn[0]  <= op_p0;
                for (int i = 1; i < PIPE_STAGES-1; i++) begin
                    vld_pn[i] <= vld_pn[i-1];
                    op_pn[i]  <= op_pn[i-1];
                end
            end
        end
        assign vld_res = vld_pn[PIPE_STAGES-2];
        assign op_res  = op_pn[PIPE_STAGES-2];
    end

    // Result stage: valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dsp_out_vld <= 1'b0;
        else if (dsp_ce) dsp_out_vld <= vld_res;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dsp_mac_lane #(
            .PIPE_STAGES(PIPE_STAGES),
            .SIGNED_MODE(SIGNED_MODE)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .ce   (dsp_ce),
            .vld  (vld_res),
            .op   (op_res),
            .a    (dsp_a0[i*DSP_A_W +: DSP_A_W]),
            .b    (dsp_b0[i*DSP_A_W +: DSP_A_W]),
            .out  (dsp_out[i*DSP_OUT_W +: DSP_OUT_W]),
            .ovf  (dsp_ovf[i])
        );
    end

endmodule
